mem_rd_burst_responder: RTL and testbench
=========================================

Name: mem_rd_burst_responder

Overview:
- Memory-side responder for the cache read-burst interface; the opposite end of the instruction/data cache miss path.
- Accepts one 32-byte-aligned line read request at a time.
- Returns the line as 8 sequential 32-bit beats from an internal word-addressed memory array, with `last` on beat 7 and full valid/ready backpressure.
- Used as the memory model in cache benches and as a simple on-chip line memory; contents are loaded through a side write port.

Parameters:
- MEM_ADDR_W, 10: word-address width; the array holds 2^MEM_ADDR_W 32-bit words. Minimum 3.
- RD_LATENCY, 2: idle cycles between request acceptance and the first response beat. Range 0..15.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- from_cache_rd_req_valid  input  1  read request valid
- from_cache_rd_req_addr  input  32  request byte address; bits [4:0] ignored
- to_cache_rd_req_ready  output  1  responder can accept a request
- to_cache_rd_rsp_valid  output  1  response beat valid
- to_cache_rd_rsp_data  output  32  response beat data
- to_cache_rd_rsp_last  output  1  current beat is the final (8th) beat
- from_cache_rd_rsp_ready  input  1  requester accepts the current beat
- init_wr_en  input  1  side-port word write enable
- init_wr_addr  input  32  side-port byte address; bits [MEM_ADDR_W+1:2] are used
- init_wr_data  input  32  side-port write data

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Reset values: state=IDLE, beat=0, lat_cnt=0, line=0.
  - to_cache_rd_req_ready=1 in the first cycle after reset.
  - to_cache_rd_rsp_valid=0, to_cache_rd_rsp_last=0.
  - to_cache_rd_rsp_data is don't-care while valid=0.
  - Memory array is not reset.
- States: IDLE, LAT, BURST. State register is one-hot or binary, implementer's choice.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready: latch line = addr[MEM_ADDR_W+1:5] and set beat=0.
  - If RD_LATENCY>0: load lat_cnt=RD_LATENCY-1 and go to LAT.
  - If RD_LATENCY=0: go directly to BURST.
- LAT:
  - req_ready=0, rsp_valid=0.
  - Decrement lat_cnt each cycle; at lat_cnt=0 go to BURST.
  - Result: first rsp_valid appears exactly RD_LATENCY+1 cycles after the accepting edge.
- BURST:
  - rsp_valid=1, req_ready=0.
  - rsp_data = mem[{line, beat}] as a combinational read.
  - rsp_last = (beat==7).
  - On rsp_valid & rsp_ready: if beat<7, beat increments; if beat==7, go to IDLE.
  - IDLE is entered with req_ready=1 in the following cycle, so there is one dead cycle between bursts.
  - While rsp_ready=0: beat holds, and valid/data/last remain stable (data can change only via an init write to that same word).
- Address rules:
  - Request addr bits [4:0] are ignored, so an unaligned request returns the enclosing line starting at beat 0 (no critical-word-first).
  - Address bits above MEM_ADDR_W+1 are ignored: addresses alias modulo 2^(MEM_ADDR_W+2) bytes.
  - The beat counter is 3 bits; the burst never crosses a line boundary.
- Init port:
  - Writes mem[init_wr_addr[MEM_ADDR_W+1:2]] <= init_wr_data on any cycle where init_wr_en=1, in any state.
  - The side port ignores rst.
  - A write to the word currently being presented is visible on rsp_data in the next cycle.
  - A write to a later beat of the active line is returned when that beat is reached.
- Only one outstanding request; no request queuing.
- req_valid asserted outside IDLE is not accepted and is not remembered.
- Reset mid-operation (LAT or BURST): next cycle state=IDLE, rsp_valid=0, rsp_last=0, req_ready=1; the remainder of the burst is discarded. Memory contents are retained.

Test Plan:
- Preload words 0x10..0x17 (byte addr 0x40..0x5C) with 0xA0000000+i. Request 0x00000040 with rsp_ready=1 and RD_LATENCY=2, accepting edge at cycle T.
  -> rsp_valid at T+3..T+10, data 0xA0000000..0xA0000007, last only at T+10, req_ready=1 at T+11.
- Same request, rsp_ready toggled 1,0,0,1,...
  -> each beat is held stable while ready=0; exactly 8 handshakes; data in order; last on the 8th handshake only.
- Request 0x0000004C; separately, request 0x00001040 with MEM_ADDR_W=10.
  -> both return the same 8 words as the request to 0x40 (offset ignored; 4 KiB aliasing).
- Two requests back-to-back (valid held high) to lines 0x40 and 0x60.
  -> second accepted in the cycle after the first burst's last handshake; no beat lost or duplicated.
- Assert rst during beat 3 of a burst.
  -> next cycle rsp_valid=0, req_ready=1; a new request to 0x40 returns all 8 original words.
- RD_LATENCY=0 with an init write to word 0x15 during beat 2.
  -> first rsp_valid one cycle after accept; beat 5 returns the newly written value.

Source files
------------

// File: rtl/mem_rd_burst_responder.sv
// mem_rd_burst_responder: returns one 32-byte line as 8 beats from a word array after a fixed latency.
// The array is loaded through a side write port that is independent of rst.
module mem_rd_burst_responder #(
   parameter int MEM_ADDR_W = 10,
   parameter int RD_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        from_cache_rd_req_valid,
   input  logic [31:0] from_cache_rd_req_addr,
   output logic        to_cache_rd_req_ready,
   output logic        to_cache_rd_rsp_valid,
   output logic [31:0] to_cache_rd_rsp_data,
   output logic        to_cache_rd_rsp_last,
   input  logic        from_cache_rd_rsp_ready,
   input  logic        init_wr_en,
   input  logic [31:0] init_wr_addr,
   input  logic [31:0] init_wr_data
);
   typedef enum logic [1:0] {IDLE, LAT, BURST} state_t;
   state_t                state;
   logic [2:0]            beat;
   logic [3:0]            lat_cnt;
   logic [MEM_ADDR_W-1:0] line_base;
   logic [31:0]           mem [0:2**MEM_ADDR_W-1];
   logic                  unused_bits;
   assign unused_bits = ^{from_cache_rd_req_addr[31:MEM_ADDR_W+2], from_cache_rd_req_addr[4:0],
                          init_wr_addr[31:MEM_ADDR_W+2], init_wr_addr[1:0]};
   // line_base keeps the word index of beat 0; the beat is OR-ed into its zero low bits
   assign to_cache_rd_rsp_data = mem[line_base | MEM_ADDR_W'(beat)];
   always_ff @(posedge clk)
      if (init_wr_en) mem[init_wr_addr[MEM_ADDR_W+1:2]] <= init_wr_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= IDLE;
         beat                  <= 3'd0;
         lat_cnt               <= 4'd0;
         line_base             <= '0;
         to_cache_rd_req_ready <= 1'b1;
         to_cache_rd_rsp_valid <= 1'b0;
         to_cache_rd_rsp_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (from_cache_rd_req_valid) begin
               line_base             <= from_cache_rd_req_addr[MEM_ADDR_W+1:2] & ~MEM_ADDR_W'(7);
               beat                  <= 3'd0;
               to_cache_rd_req_ready <= 1'b0;
               if (RD_LATENCY > 0) begin
                  lat_cnt <= 4'(RD_LATENCY - 1);
                  state   <= LAT;
               end else begin
                  state                 <= BURST;
                  to_cache_rd_rsp_valid <= 1'b1;
               end
            end
            LAT: if (lat_cnt == 4'd0) begin
               state                 <= BURST;
               to_cache_rd_rsp_valid <= 1'b1;
            end else begin
               lat_cnt <= lat_cnt - 4'd1;
            end
            BURST: if (from_cache_rd_rsp_ready) begin
               if (beat == 3'd7) begin
                  state                 <= IDLE;
                  to_cache_rd_rsp_valid <= 1'b0;
                  to_cache_rd_rsp_last  <= 1'b0;
                  to_cache_rd_req_ready <= 1'b1;
               end else begin
                  beat                 <= beat + 3'd1;
                  to_cache_rd_rsp_last <= (beat == 3'd6);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_rd_burst_responder.sv
// tb_mem_rd_burst_responder: checks two responders (latency 2 and latency 0) against a
// transaction-level model: a shadow word array plus latency/beat arithmetic.
module tb_mem_rd_burst_responder;
   logic        clk, rst;
   logic        req_valid [2];
   logic [31:0] req_addr [2];
   logic        req_ready [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_data [2];
   logic        rsp_last [2];
   logic        rsp_ready [2];
   logic        wr_en [2];
   logic [31:0] wr_addr [2];
   logic [31:0] wr_data [2];
   logic [31:0] ref_mem [2][1024];
   int          tests, fails, last_wait;

   mem_rd_burst_responder #(.MEM_ADDR_W(10), .RD_LATENCY(2)) u0 (
      .clk(clk), .rst(rst),
      .from_cache_rd_req_valid(req_valid[0]), .from_cache_rd_req_addr(req_addr[0]),
      .to_cache_rd_req_ready(req_ready[0]), .to_cache_rd_rsp_valid(rsp_valid[0]),
      .to_cache_rd_rsp_data(rsp_data[0]), .to_cache_rd_rsp_last(rsp_last[0]),
      .from_cache_rd_rsp_ready(rsp_ready[0]), .init_wr_en(wr_en[0]),
      .init_wr_addr(wr_addr[0]), .init_wr_data(wr_data[0]));

   mem_rd_burst_responder #(.MEM_ADDR_W(10), .RD_LATENCY(0)) u1 (
      .clk(clk), .rst(rst),
      .from_cache_rd_req_valid(req_valid[1]), .from_cache_rd_req_addr(req_addr[1]),
      .to_cache_rd_req_ready(req_ready[1]), .to_cache_rd_rsp_valid(rsp_valid[1]),
      .to_cache_rd_rsp_data(rsp_data[1]), .to_cache_rd_rsp_last(rsp_last[1]),
      .from_cache_rd_rsp_ready(rsp_ready[1]), .init_wr_en(wr_en[1]),
      .init_wr_addr(wr_addr[1]), .init_wr_data(wr_data[1]));

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endfunction

   // One clock edge; the shadow memory takes the same write the DUT sees, then outputs are sampled at +1.
   task automatic step();
      @(posedge clk);
      for (int d = 0; d < 2; d++)
         if (wr_en[d]) ref_mem[d][wr_addr[d][11:2]] = wr_data[d];
      #1;
   endtask

   // mode: 0 always ready, 1 ready pattern 1,0,0,..., 2 random ready plus random init writes
   task automatic burst(input int d, input logic [31:0] addr, input int widx, input int mode,
                        input bit keep_valid, input int wr_k, input int wr_word, input logic [31:0] wr_val);
      int lat, k, cyc;
      bit hs;
      lat = (d == 0) ? 2 : 0;
      req_valid[d] = 1;
      req_addr[d]  = addr;
      last_wait    = 0;
      while (!req_ready[d] && last_wait < 50) begin step(); last_wait++; end
      chk("req_ready_before_accept", 32'(req_ready[d]), 1);
      step();
      if (!keep_valid) req_valid[d] = 0;
      for (int i = 0; i < lat; i++) begin
         chk("lat_valid", 32'(rsp_valid[d]), 0);
         chk("lat_req_ready", 32'(req_ready[d]), 0);
         step();
      end
      k = 0;
      cyc = 0;
      while (k < 8 && cyc < 300) begin
         chk("beat_valid", 32'(rsp_valid[d]), 1);
         chk("beat_data", rsp_data[d], ref_mem[d][widx + k]);
         chk("beat_last", 32'(rsp_last[d]), (k == 7) ? 1 : 0);
         chk("beat_req_ready", 32'(req_ready[d]), 0);
         rsp_ready[d] = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom % 2);
         if (k == wr_k) begin
            wr_en[d] = 1; wr_addr[d] = 32'(wr_word) << 2; wr_data[d] = wr_val;
         end else if (mode == 2 && $urandom % 4 == 0) begin
            wr_en[d]   = 1;
            wr_addr[d] = ($urandom % 2) ? 32'(widx + int'($urandom % 8)) << 2 : $urandom;
            wr_data[d] = $urandom;
         end
         hs = rsp_ready[d];
         step();
         wr_en[d] = 0;
         if (hs) k++;
         cyc++;
      end
      chk("burst_handshakes", 32'(k), 8);
      rsp_ready[d] = 0;
      chk("post_valid", 32'(rsp_valid[d]), 0);
      chk("post_last", 32'(rsp_last[d]), 0);
      chk("post_req_ready", 32'(req_ready[d]), 1);
   endtask

   typedef struct {
      logic [31:0] addr;
      int          widx;
      int          mode;
   } vec_t;
   vec_t tbl[8];

   initial begin
      logic [31:0] a;
      tests = 0; fails = 0;
      tbl[0] = '{32'h0000_0040, 'h10, 0};
      tbl[1] = '{32'h0000_0040, 'h10, 1};
      tbl[2] = '{32'h0000_004C, 'h10, 0};
      tbl[3] = '{32'h0000_1040, 'h10, 0};
      tbl[4] = '{32'hFFFF_F05F, 'h10, 1};
      tbl[5] = '{32'h0000_0060, 'h18, 0};
      tbl[6] = '{32'h0000_0FE4, 'h3F8, 1};
      tbl[7] = '{32'h0000_0000, 'h0, 0};
      rst = 1;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 0; req_addr[d] = 0; rsp_ready[d] = 0;
         wr_en[d] = 0; wr_addr[d] = 0; wr_data[d] = 0;
      end
      step(); step();
      for (int d = 0; d < 2; d++) begin
         chk("reset_req_ready", 32'(req_ready[d]), 1);
         chk("reset_valid", 32'(rsp_valid[d]), 0);
         chk("reset_last", 32'(rsp_last[d]), 0);
      end
      rst = 0;
      for (int i = 0; i < 1024; i++) begin
         for (int d = 0; d < 2; d++) begin
            wr_en[d] = 1; wr_addr[d] = 32'(i) << 2;
            wr_data[d] = (i >= 'h10 && i < 'h18) ? 32'hA000_0000 + 32'(i - 'h10) : $urandom;
         end
         step();
      end
      wr_en[0] = 0; wr_en[1] = 0;
      for (int i = 0; i < 8; i++) chk("preload_ref", ref_mem[0]['h10 + i], 32'hA000_0000 + 32'(i));
      for (int i = 0; i < 8; i++) burst(0, tbl[i].addr, tbl[i].widx, tbl[i].mode, 0, -1, 0, 0);
      step();
      // back-to-back: valid held high, second request accepted right after the last handshake
      burst(0, 32'h40, 'h10, 0, 1, -1, 0, 0);
      burst(0, 32'h60, 'h18, 0, 0, -1, 0, 0);
      chk("b2b_no_wait", 32'(last_wait), 0);
      step();
      // reset while beat 3 is presented
      req_valid[0] = 1; req_addr[0] = 32'h40;
      step();
      req_valid[0] = 0;
      step(); step();
      rsp_ready[0] = 1;
      step(); step(); step();
      rsp_ready[0] = 0;
      chk("pre_rst_beat3_data", rsp_data[0], 32'hA000_0003);
      rst = 1;
      step();
      rst = 0;
      chk("mid_rst_valid", 32'(rsp_valid[0]), 0);
      chk("mid_rst_last", 32'(rsp_last[0]), 0);
      chk("mid_rst_req_ready", 32'(req_ready[0]), 1);
      burst(0, 32'h40, 'h10, 0, 0, -1, 0, 0);
      // latency 0 with a write to word 0x15 while beat 2 is presented
      burst(1, 32'h40, 'h10, 0, 0, 2, 'h15, 32'h5EED_0015);
      chk("lat0_written_word", ref_mem[1]['h15], 32'h5EED_0015);
      // write to the word currently presented while stalled
      req_valid[1] = 1; req_addr[1] = 32'h40;
      step();
      req_valid[1] = 0;
      chk("stall_data_before", rsp_data[1], 32'hA000_0000);
      wr_en[1] = 1; wr_addr[1] = 32'h40; wr_data[1] = 32'hCAFE_0000;
      step();
      wr_en[1] = 0;
      chk("stall_data_after_write", rsp_data[1], 32'hCAFE_0000);
      rsp_ready[1] = 1;
      for (int i = 0; i < 8; i++) step();
      rsp_ready[1] = 0;
      chk("stall_burst_done", 32'(req_ready[1]), 1);
      for (int t = 0; t < 40; t++) begin
         int d;
         d = int'($urandom % 2);
         a = $urandom;
         burst(d, a, int'(a % 4096) / 32 * 8, 2, 0, -1, 0, 0);
         if ($urandom % 2 == 1) step();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
